// File: rtl/bus_arbiter.sv
// bus_arbiter: shared-bus arbiter with fixed or round-robin priority, burst limit,
// BUS_ready watchdog and a one-cycle release turnaround between owners.
module bus_arbiter #(
    parameter int N_MASTERS = 8,
    parameter int MODE      = 0,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic [N_MASTERS-1:0]         DMA,
    output logic [N_MASTERS-1:0]         grant,
    output logic                         BUS_req,
    input  logic                         BUS_ready,
    output logic [$clog2(N_MASTERS)-1:0] owner,
    output logic                         bus_err
);
    localparam int OW = $clog2(N_MASTERS);
    localparam int BW = MAX_BURST > 0 ? $clog2(MAX_BURST + 1) : 1;
    localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    state_t                 r_state, w_state;
    logic [N_MASTERS-1:0]   r_grant, w_grant;
    logic                   r_req;
    logic [OW-1:0]          r_owner, w_owner, r_rr, w_rr, w_win, w_idx;
    logic                   w_found;
    logic                   r_err, w_err;
    logic [BW-1:0]          r_beat, w_beat;
    logic [WW-1:0]          r_wait, w_wait;
    logic                   w_tmo, w_last, w_others;
    assign w_tmo    = (TIMEOUT != 0) && !BUS_ready && (r_wait == WW'(TIMEOUT - 1));
    assign w_last   = (MAX_BURST != 0) && (r_beat == BW'(MAX_BURST - 1));
    assign w_others = |(DMA & ~r_grant);
    // Scan order starts at 0 (fixed) or just past the last winner (round-robin).
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            w_idx = (MODE == 1) ? OW'((int'(r_rr) + 1 + k) % N_MASTERS) : OW'(k);
            if (!w_found && DMA[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end
    always_comb begin
        w_state = r_state;
        w_grant = r_grant;
        w_owner = r_owner;
        w_rr    = r_rr;
        w_err   = 1'b0;
        w_beat  = r_beat;
        w_wait  = r_wait;
        case (r_state)
            IDLE: begin
                if (|DMA) begin
                    w_state = GRANT;
                    w_grant = {{(N_MASTERS-1){1'b0}}, 1'b1} << w_win;
                    w_owner = w_win;
                    w_beat  = '0;
                    w_wait  = '0;
                    w_rr    = (MODE == 1) ? w_win : r_rr;
                end
            end
            GRANT: begin
                if (w_tmo) begin
                    w_state = RELEASE;
                    w_grant = '0;
                    w_err   = 1'b1;
                end else if (!DMA[r_owner] || (BUS_ready && w_last && w_others)) begin
                    w_state = RELEASE;
                    w_grant = '0;
                end else if (BUS_ready) begin
                    w_beat = w_last ? '0 : r_beat + 1'b1;
                    w_wait = '0;
                end else begin
                    w_wait = (r_wait == '1) ? r_wait : r_wait + 1'b1;
                end
            end
            default: begin
                w_state = IDLE;
                w_grant = '0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_req   <= 1'b0;
            r_owner <= '0;
            r_rr    <= OW'(N_MASTERS - 1);
            r_err   <= 1'b0;
            r_beat  <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state;
            r_grant <= w_grant;
            r_req   <= |w_grant;
            r_owner <= w_owner;
            r_rr    <= w_rr;
            r_err   <= w_err;
            r_beat  <= w_beat;
            r_wait  <= w_wait;
        end
    end
    assign grant   = r_grant;
    assign BUS_req = r_req;
    assign owner   = r_owner;
    assign bus_err = r_err;
endmodule
